// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its neighbours:
// control-FSM state codes, fetch-fsm encoding, instruction field layout
// and opcode constants.
package instruction_fetch_unit_pkg;

    // Control-FSM state codes (the control FSM's Output bus)
    localparam logic [3:0] CTL_FETCH     = 4'b1000;
    localparam logic [3:0] CTL_DECODE    = 4'b0100;
    localparam logic [3:0] CTL_WRITEBACK = 4'b1001;

    // Execute states are encoded as {1'b0, opcode}
    function automatic logic [3:0] ctl_execute(input logic [2:0] op);
        return {1'b0, op};
    endfunction

    // Fetch-fsm encoding
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_DONE = 2'b10
    } fetch_state_e;

    // Instruction field layout: opcode occupies the top OPCODE_W bits,
    // the operand fills everything below it
    localparam int unsigned OPCODE_W = 3;

    // Opcode constants
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_AND   = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_JZ    = 3'b111;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register.
//  Clock      in   rising-edge clock
//  Clear      in   synchronous active-high reset, loads PC_RESET
//  Load       in   load Load_Value (branch / jump)
//  Load_Value in   new PC value
//  Inc        in   advance by one, modulo 2^ADDR_W
//  Q          out  current PC
// Priority: Clear > Load > Inc.
module program_counter #(
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]    PC_RESET = {ADDR_W{1'b0}}
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Load,
    input  logic [ADDR_W-1:0] Load_Value,
    input  logic              Inc,
    output logic [ADDR_W-1:0] Q
);

    logic [ADDR_W-1:0] q_r;

    // PC register; the increment wraps silently at all-ones
    always_ff @(posedge Clock) begin
        if (Clear) begin
            q_r <= PC_RESET;
        end else if (Load) begin
            q_r <= Load_Value;
        end else if (Inc) begin
            q_r <= q_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            q_r <= q_r;
        end
    end

    assign Q = q_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC and the instruction register and
// fetches one instruction each time the control FSM sits in FETCH_STATE.
//  Clock/Clear          rising-edge clock, synchronous active-high reset
//  State                control-FSM state code
//  Load_PC/Load_Value   branch/jump PC load
//  Mem_Addr/Mem_Rd      registered read request to program memory
//  Mem_Data/Mem_Valid   read response (Valid only honoured while requesting)
//  OPCODE/Operand       slices of the instruction register
//  PC                   current program counter
//  Instr_Valid          one-cycle pulse when the IR loads
//  Stall                combinational hold request to the control FSM
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       INSTR_W     = 16,
    parameter logic [3:0]        FETCH_STATE = CTL_FETCH,
    parameter logic [ADDR_W-1:0] PC_RESET    = {ADDR_W{1'b0}}
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic [3:0]            State,
    input  logic                  Load_PC,
    input  logic [ADDR_W-1:0]     Load_Value,
    output logic [ADDR_W-1:0]     Mem_Addr,
    output logic                  Mem_Rd,
    input  logic [INSTR_W-1:0]    Mem_Data,
    input  logic                  Mem_Valid,
    output logic [OPCODE_W-1:0]   OPCODE,
    output logic [INSTR_W-4:0]    Operand,
    output logic [ADDR_W-1:0]     PC,
    output logic                  Instr_Valid,
    output logic                  Stall
);

    fetch_state_e         state_r;
    fetch_state_e         next_state_s;
    logic                 fetch_req_s;
    logic                 start_s;
    logic                 complete_s;
    logic [INSTR_W-1:0]   ir_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic                 mem_rd_r;
    logic                 instr_valid_r;
    logic [ADDR_W-1:0]    pc_s;

    assign fetch_req_s = (State == FETCH_STATE);

    // Fetch-fsm state register
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_r <= FETCH_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Fetch-fsm next state plus request-start / fetch-complete strobes.
    // Mem_Valid is only looked at in REQ, so stray responses are dropped.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        complete_s   = 1'b0;
        case (state_r)
            FETCH_IDLE: begin
                if (fetch_req_s) begin
                    next_state_s = FETCH_REQ;
                    start_s      = 1'b1;
                end else begin
                    next_state_s = FETCH_IDLE;
                end
            end
            FETCH_REQ: begin
                if (Mem_Valid) begin
                    complete_s = 1'b1;
                    // A read that outlived its FETCH goes straight back to IDLE
                    if (fetch_req_s) begin
                        next_state_s = FETCH_DONE;
                    end else begin
                        next_state_s = FETCH_IDLE;
                    end
                end else begin
                    next_state_s = FETCH_REQ;
                end
            end
            FETCH_DONE: begin
                // Holding in DONE while FETCH persists prevents a refetch
                if (fetch_req_s) begin
                    next_state_s = FETCH_DONE;
                end else begin
                    next_state_s = FETCH_IDLE;
                end
            end
            default: begin
                next_state_s = FETCH_IDLE;
            end
        endcase
    end

    // Memory request, instruction register and load pulse
    always_ff @(posedge Clock) begin
        if (Clear) begin
            mem_rd_r      <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            ir_r          <= {INSTR_W{1'b0}};
            instr_valid_r <= 1'b0;
        end else begin
            if (start_s) begin
                mem_rd_r   <= 1'b1;
                mem_addr_r <= pc_s;
            end else if (complete_s) begin
                mem_rd_r   <= 1'b0;
                mem_addr_r <= mem_addr_r;
            end else begin
                mem_rd_r   <= mem_rd_r;
                mem_addr_r <= mem_addr_r;
            end
            if (complete_s) begin
                ir_r <= Mem_Data;
            end else begin
                ir_r <= ir_r;
            end
            instr_valid_r <= complete_s;
        end
    end

    program_counter #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RESET)
    ) u_program_counter (
        .Clock      (Clock),
        .Clear      (Clear),
        .Load       (Load_PC),
        .Load_Value (Load_Value),
        .Inc        (complete_s),
        .Q          (pc_s)
    );

    assign Mem_Addr    = mem_addr_r;
    assign Mem_Rd      = mem_rd_r;
    assign OPCODE      = ir_r[INSTR_W-1 -: OPCODE_W];
    assign Operand     = ir_r[INSTR_W-4:0];
    assign PC          = pc_s;
    assign Instr_Valid = instr_valid_r;
    assign Stall       = fetch_req_s && (state_r != FETCH_DONE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [3:0] ST_FETCH  = 4'b1000;
    localparam logic [3:0] ST_DECODE = 4'b0100;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [3:0]  State;
    logic        Load_PC;
    logic [7:0]  Load_Value;
    logic [7:0]  Mem_Addr;
    logic        Mem_Rd;
    logic [15:0] Mem_Data;
    logic        Mem_Valid;
    logic [2:0]  OPCODE;
    logic [12:0] Operand;
    logic [7:0]  PC;
    logic        Instr_Valid;
    logic        Stall;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_pc;
    logic [15:0] model_ir;

    always #5 Clock = ~Clock;

    instruction_fetch_unit dut (
        .Clock       (Clock),
        .Clear       (Clear),
        .State       (State),
        .Load_PC     (Load_PC),
        .Load_Value  (Load_Value),
        .Mem_Addr    (Mem_Addr),
        .Mem_Rd      (Mem_Rd),
        .Mem_Data    (Mem_Data),
        .Mem_Valid   (Mem_Valid),
        .OPCODE      (OPCODE),
        .Operand     (Operand),
        .PC          (PC),
        .Instr_Valid (Instr_Valid),
        .Stall       (Stall)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_ir(input string tag);
        chk_eq({tag, "_opcode"}, {29'd0, OPCODE}, {29'd0, model_ir[15:13]});
        chk_eq({tag, "_operand"}, {19'd0, Operand}, {19'd0, model_ir[12:0]});
    endtask

    // One complete fetch transaction, starting and ending with the unit idle
    task automatic do_fetch(input int waits, input logic [15:0] data,
                            input logic load_end, input logic [7:0] lv_end,
                            input logic mid_load, input logic [7:0] lv_mid,
                            input logic leave, input int hold);
        logic [7:0] addr;
        addr      = model_pc;
        State     = ST_FETCH;
        Mem_Valid = 1'($urandom);   // not requesting yet: must be ignored
        Mem_Data  = 16'($urandom);
        #1;
        chk_eq("stall_req", {31'd0, Stall}, 32'd1);
        chk_eq("rd_before", {31'd0, Mem_Rd}, 32'd0);
        step();
        Mem_Valid = 1'b0;
        chk_eq("rd_start", {31'd0, Mem_Rd}, 32'd1);
        chk_eq("addr_start", {24'd0, Mem_Addr}, {24'd0, addr});
        chk_eq("iv_start", {31'd0, Instr_Valid}, 32'd0);
        chk_ir("ir_start");
        for (int w = 0; w < waits; w++) begin
            if (w == 0 && mid_load) begin
                Load_PC    = 1'b1;
                Load_Value = lv_mid;
            end
            step();
            if (w == 0 && mid_load) begin
                model_pc = lv_mid;
            end
            Load_PC = 1'b0;
            chk_eq("rd_wait", {31'd0, Mem_Rd}, 32'd1);
            chk_eq("addr_wait", {24'd0, Mem_Addr}, {24'd0, addr});
            chk_eq("pc_wait", {24'd0, PC}, {24'd0, model_pc});
            chk_eq("iv_wait", {31'd0, Instr_Valid}, 32'd0);
            chk_eq("stall_wait", {31'd0, Stall}, 32'd1);
        end
        Mem_Valid  = 1'b1;
        Mem_Data   = data;
        Load_PC    = load_end;
        Load_Value = lv_end;
        if (leave) begin
            State = ST_DECODE;
        end
        step();
        Mem_Valid = 1'b0;
        Load_PC   = 1'b0;
        model_ir  = data;
        model_pc  = load_end ? lv_end : 8'(model_pc + 8'd1);
        chk_eq("iv_done", {31'd0, Instr_Valid}, 32'd1);
        chk_eq("rd_done", {31'd0, Mem_Rd}, 32'd0);
        chk_eq("pc_done", {24'd0, PC}, {24'd0, model_pc});
        chk_eq("stall_done", {31'd0, Stall}, 32'd0);
        chk_ir("ir_done");
        if (!leave) begin
            for (int h = 0; h < hold; h++) begin
                Mem_Valid = 1'($urandom);
                Mem_Data  = 16'($urandom);
                step();
                chk_eq("iv_hold", {31'd0, Instr_Valid}, 32'd0);
                chk_eq("rd_hold", {31'd0, Mem_Rd}, 32'd0);
                chk_eq("stall_hold", {31'd0, Stall}, 32'd0);
                chk_ir("ir_hold");
            end
        end
        Mem_Valid = 1'b0;
        State     = ST_DECODE;
        step();
        chk_eq("iv_exit", {31'd0, Instr_Valid}, 32'd0);
        chk_eq("rd_exit", {31'd0, Mem_Rd}, 32'd0);
        chk_eq("pc_exit", {24'd0, PC}, {24'd0, model_pc});
    endtask

    initial begin
        Clear      = 1'b1;
        State      = 4'b0000;
        Load_PC    = 1'b0;
        Load_Value = 8'h00;
        Mem_Data   = 16'h0000;
        Mem_Valid  = 1'b0;
        model_pc   = 8'h00;
        model_ir   = 16'h0000;

        // 1. reset
        step();
        step();
        chk_eq("rst_pc", {24'd0, PC}, 32'd0);
        chk_ir("rst_ir");
        chk_eq("rst_rd", {31'd0, Mem_Rd}, 32'd0);
        chk_eq("rst_addr", {24'd0, Mem_Addr}, 32'd0);
        chk_eq("rst_iv", {31'd0, Instr_Valid}, 32'd0);
        chk_eq("rst_stall", {31'd0, Stall}, 32'd0);
        Clear = 1'b0;
        step();

        // 2. zero-wait fetch of A5C3
        do_fetch(0, 16'hA5C3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1);
        chk_eq("t2_opcode", {29'd0, OPCODE}, 32'h5);
        chk_eq("t2_operand", {19'd0, Operand}, 32'h05C3);
        chk_eq("t2_pc", {24'd0, PC}, 32'h01);

        // 3. three wait cycles
        do_fetch(3, 16'h3C21, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0);

        // 4. wrap at FF, then load on the completing cycle
        Load_PC    = 1'b1;
        Load_Value = 8'hFF;
        step();
        Load_PC  = 1'b0;
        model_pc = 8'hFF;
        chk_eq("t4_preload", {24'd0, PC}, 32'hFF);
        do_fetch(1, 16'h1234, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        chk_eq("t4_wrap", {24'd0, PC}, 32'h00);
        do_fetch(0, 16'hE001, 1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 0);
        chk_eq("t4_load", {24'd0, PC}, 32'h40);

        // 5. Clear during REQ, late Mem_Valid ignored
        State = ST_FETCH;
        step();
        chk_eq("t5_rd_req", {31'd0, Mem_Rd}, 32'd1);
        Clear = 1'b1;
        State = 4'b0000;
        step();
        Clear     = 1'b0;
        model_pc  = 8'h00;
        model_ir  = 16'h0000;
        chk_eq("t5_rd_clr", {31'd0, Mem_Rd}, 32'd0);
        Mem_Valid = 1'b1;
        Mem_Data  = 16'hFFFF;
        step();
        Mem_Valid = 1'b0;
        chk_ir("t5_ir");
        chk_eq("t5_iv", {31'd0, Instr_Valid}, 32'd0);
        chk_eq("t5_rd", {31'd0, Mem_Rd}, 32'd0);
        chk_eq("t5_pc", {24'd0, PC}, 32'h00);

        // 6. long FETCH hold: one read, then a second read at the new PC
        do_fetch(0, 16'h8ABC, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 10);
        do_fetch(2, 16'h4321, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        chk_eq("t6_pc", {24'd0, PC}, 32'h02);

        // Leaving FETCH during REQ and loading PC mid-request
        do_fetch(2, 16'h7777, 1'b0, 8'h00, 1'b1, 8'h90, 1'b1, 0);
        chk_eq("leave_pc", {24'd0, PC}, 32'h91);

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            int         waits;
            logic       mid;
            waits = int'($urandom_range(0, 4));
            mid   = (waits > 0) && ($urandom_range(0, 3) == 0);
            do_fetch(waits, 16'($urandom),
                     ($urandom_range(0, 3) == 0), 8'($urandom),
                     mid, 8'($urandom),
                     ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
